rf_wb_scheduler: RTL

//  Write-back scheduler for the 32x32 register file (single write port: regWEn/rd/DataD).

---
 rtl/rf_wb_scheduler_pkg.sv | 17 +
 rtl/rf_wb_scheduler_if.sv | 49 ++++
 rtl/rf_wb_scheduler_scoreboard.sv | 54 +++++
 rtl/rf_wb_scheduler.sv | 102 ++++++++++
 4 files changed

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared parameters, types and source encoding for the register-file write-back scheduler.
package rf_sched_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned AW         = 5;
    localparam int unsigned STARVE_MAX = 4;

    typedef logic [AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LSU
    } wb_src_t;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of ALU/LSU write-back streams, issue hazard port and register-file write port.
interface rf_wb_scheduler_if;
    import rf_sched_pkg::*;

    logic            alu_valid;
    reg_idx_t        alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    reg_idx_t        lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            iss_valid;
    reg_idx_t        iss_rs1;
    reg_idx_t        iss_rs2;
    reg_idx_t        iss_rd;
    logic            iss_wr;
    logic            iss_stall;

    logic            rf_we;
    reg_idx_t        rf_rd;
    logic [XLEN-1:0] rf_data;
    logic [NREG-1:0] busy;

    // Scheduler side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        output iss_stall,
        output rf_we, rf_rd, rf_data, busy
    );

    // Producer / decode / register-file side
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wr,
        input  iss_stall,
        input  rf_we, rf_rd, rf_data, busy
    );

endinterface

// File: rtl/rf_wb_scheduler_scoreboard.sv
// Per-register busy scoreboard with RAW/WAW hazard detection; x0 is never busy.
module rf_scoreboard
    import rf_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  reg_idx_t        set_idx,
    input  logic            clr_en,
    input  reg_idx_t        clr_idx,
    input  logic            iss_valid,
    input  reg_idx_t        iss_rs1,
    input  reg_idx_t        iss_rs2,
    input  reg_idx_t        iss_rd,
    input  logic            iss_wr,
    output logic [NREG-1:0] busy,
    output logic            iss_stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next busy vector: clear first so a same-edge set of the same index wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard compare against current busy bits (no bypass)
    always_comb begin
        iss_stall = iss_valid &
                    (((iss_rs1 != '0) & busy_q[iss_rs1]) |
                     ((iss_rs2 != '0) & busy_q[iss_rs2]) |
                     (iss_wr & (iss_rd != '0) & busy_q[iss_rd]));
    end

    assign busy = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler: arbitrates ALU/LSU results onto the single register-file write port.
module rf_wb_scheduler
    import rf_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rf_wb_scheduler_if.slave bus
);

    wb_src_t         win;
    logic [3:0]      starve_cnt_q, starve_cnt_d;
    logic            rf_we_q, rf_we_d;
    reg_idx_t        rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            set_en;
    logic            iss_stall;
    logic [NREG-1:0] busy;

    // Arbiter: LSU by default, ALU once it has lost STARVE_MAX cycles in a row
    always_comb begin
        win = SRC_NONE;
        if (!rst) begin
            if (bus.alu_valid && bus.lsu_valid) begin
                win = (starve_cnt_q == 4'(STARVE_MAX)) ? SRC_ALU : SRC_LSU;
            end else if (bus.lsu_valid) begin
                win = SRC_LSU;
            end else if (bus.alu_valid) begin
                win = SRC_ALU;
            end
        end
    end

    assign bus.alu_ready = (win == SRC_ALU);
    assign bus.lsu_ready = (win == SRC_LSU);

    // Starve counter and output-stage next values
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.alu_valid || bus.alu_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < 4'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        case (win)
            SRC_ALU: begin
                rf_we_d   = (bus.alu_rd != '0);
                rf_rd_d   = bus.alu_rd;
                rf_data_d = bus.alu_data;
            end
            SRC_LSU: begin
                rf_we_d   = (bus.lsu_rd != '0);
                rf_rd_d   = bus.lsu_rd;
                rf_data_d = bus.lsu_data;
            end
            default: ;
        endcase
    end

    // Starve counter and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign set_en = bus.iss_valid & bus.iss_wr & ~iss_stall & (bus.iss_rd != '0);

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_idx   (bus.iss_rd),
        .clr_en    (rf_we_q),
        .clr_idx   (rf_rd_q),
        .iss_valid (bus.iss_valid),
        .iss_rs1   (bus.iss_rs1),
        .iss_rs2   (bus.iss_rs2),
        .iss_rd    (bus.iss_rd),
        .iss_wr    (bus.iss_wr),
        .busy      (busy),
        .iss_stall (iss_stall)
    );

    assign bus.iss_stall = iss_stall;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.busy      = busy;

endmodule
